matrix_elementwise_unit: RTL and testbench

Parametrised successor to the fixed 4x4 8-bit adder in the NPU datapath. Computes an element-wise operation (add, subtract, max, min) over two ROWS x COLS operand matrices. Processes one row per clock behind a start/busy/done handshake. Sits between the operand buffers and the result register file. Operands are snapshotted at start, so upstream may change them while the unit runs.

---
 rtl/matrix_ew_pkg.sv | 21 ++
 rtl/matrix_ew_lane.sv | 66 ++++++
 rtl/matrix_elementwise_unit.sv | 89 ++++++++
 tb/tb_matrix_elementwise_unit.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_ew_pkg.sv
// Shared types and helpers for the element-wise matrix unit.
package matrix_ew_pkg;

    typedef enum logic [1:0] {
        EW_ADD = 2'd0,
        EW_SUB = 2'd1,
        EW_MAX = 2'd2,
        EW_MIN = 2'd3
    } ew_mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ew_state_e;

    // Row counter width; a single-row matrix still needs one bit.
    function automatic int ctr_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/matrix_ew_lane.sv
// One combinational element lane: add/sub/max/min then output sizing.
// Saturation for narrow outputs is enabled by defining MATRIX_EW_SAT_EN.
module matrix_ew_lane
    import matrix_ew_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int OUT_W = 16
) (
    input  ew_mode_e         mode,
    input  logic [IN_W-1:0]  a,
    input  logic [IN_W-1:0]  b,
    output logic [OUT_W-1:0] result
);

    // Two guard bits hold both the add carry and the sub sign without overflow.
    localparam int RAW_W = IN_W + 2;
    localparam int EXT_W = (OUT_W > RAW_W) ? OUT_W : RAW_W;

    logic        [RAW_W-1:0] a_x;
    logic        [RAW_W-1:0] b_x;
    logic signed [RAW_W-1:0] raw;
    logic signed [EXT_W-1:0] ext;

    assign a_x = {2'b00, a};
    assign b_x = {2'b00, b};

    always_comb begin
        raw = '0;
        case (mode)
            EW_ADD:  raw = a_x + b_x;
            EW_SUB:  raw = a_x - b_x;
            EW_MAX:  raw = (a >= b) ? a_x : b_x;
            EW_MIN:  raw = (a <= b) ? a_x : b_x;
            default: raw = '0;
        endcase
    end

    // Non-sub results are non-negative, so sign extension equals zero extension.
    assign ext = EXT_W'(raw);

    if (OUT_W >= IN_W + 1) begin : g_fit
        assign result = ext[OUT_W-1:0];
    end else begin : g_narrow
`ifdef MATRIX_EW_SAT_EN
        localparam logic signed [EXT_W-1:0] UMAX = (EXT_W'(1) << OUT_W) - EXT_W'(1);
        localparam logic signed [EXT_W-1:0] SMAX = (EXT_W'(1) << (OUT_W - 1)) - EXT_W'(1);
        localparam logic signed [EXT_W-1:0] SMIN = -(EXT_W'(1) << (OUT_W - 1));

        always_comb begin
            result = ext[OUT_W-1:0];
            if (mode == EW_SUB) begin
                if (ext > SMAX) begin
                    result = SMAX[OUT_W-1:0];
                end else if (ext < SMIN) begin
                    result = SMIN[OUT_W-1:0];
                end
            end else if (ext > UMAX) begin
                result = UMAX[OUT_W-1:0];
            end
        end
`else
        assign result = ext[OUT_W-1:0];
`endif
    end

endmodule

// File: rtl/matrix_elementwise_unit.sv
// Element-wise matrix add/sub/max/min, one row per clock behind start/busy/done.
// Optional output saturation: define MATRIX_EW_SAT_EN.
module matrix_elementwise_unit
    import matrix_ew_pkg::*;
#(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int IN_W  = 8,
    parameter int OUT_W = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic [1:0]                             mode,
    input  logic [ROWS-1:0][COLS-1:0][IN_W-1:0]    a,
    input  logic [ROWS-1:0][COLS-1:0][IN_W-1:0]    b,
    output logic [ROWS-1:0][COLS-1:0][OUT_W-1:0]   c,
    output logic                                   busy,
    output logic                                   done
);

    localparam int             CW       = ctr_width(ROWS);
    localparam logic [CW-1:0]  LAST_ROW = CW'(ROWS - 1);

    ew_state_e                              state;
    logic [CW-1:0]                          row;
    ew_mode_e                               mode_q;
    logic [ROWS-1:0][COLS-1:0][IN_W-1:0]    a_q;
    logic [ROWS-1:0][COLS-1:0][IN_W-1:0]    b_q;
    logic [COLS-1:0][IN_W-1:0]              a_row;
    logic [COLS-1:0][IN_W-1:0]              b_row;
    logic [COLS-1:0][OUT_W-1:0]             lane_out;

    assign a_row = a_q[row];
    assign b_row = b_q[row];

    for (genvar j = 0; j < COLS; j++) begin : g_lane
        matrix_ew_lane #(
            .IN_W  (IN_W),
            .OUT_W (OUT_W)
        ) u_lane (
            .mode   (mode_q),
            .a      (a_row[j]),
            .b      (b_row[j]),
            .result (lane_out[j])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            row    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            mode_q <= EW_ADD;
            a_q    <= '0;
            b_q    <= '0;
            c      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // Snapshot lets upstream reuse its buffers while we run.
                    if (start) begin
                        a_q    <= a;
                        b_q    <= b;
                        mode_q <= ew_mode_e'(mode);
                        row    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    c[row] <= lane_out;
                    if (row == LAST_ROW) begin
                        row   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        row <= row + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_elementwise_unit.sv
// Scoreboard bench: stimulus pushes expected matrices, monitors pop them on done.
`timescale 1ns/1ps
module tb_matrix_elementwise_unit;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int IN_W = 8;

    typedef logic [ROWS-1:0][COLS-1:0][IN_W-1:0] mat_in_t;
    typedef logic [ROWS-1:0][COLS-1:0][15:0]     mat16_t;
    typedef logic [ROWS-1:0][COLS-1:0][7:0]      mat8_t;

    logic    clk = 1'b0;
    logic    rst;
    logic    start;
    logic    start8;
    logic [1:0] mode;
    mat_in_t a;
    mat_in_t b;
    mat16_t  c;
    mat8_t   c8;
    logic    busy, done, busy8, done8;

    int checks   = 0;
    int failures = 0;

    mat16_t q16[$];
    mat8_t  q8[$];
    mat16_t e16;
    mat8_t  e8;

    always #5 clk = ~clk;

    matrix_elementwise_unit #(.ROWS(ROWS), .COLS(COLS), .IN_W(IN_W), .OUT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .b(b),
        .c(c), .busy(busy), .done(done)
    );

    matrix_elementwise_unit #(.ROWS(ROWS), .COLS(COLS), .IN_W(IN_W), .OUT_W(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .mode(mode), .a(a), .b(b),
        .c(c8), .busy(busy8), .done(done8)
    );

    // Reference arithmetic on plain integers.
    function automatic int raw_op(input int m, input int x, input int y);
        case (m)
            0:       return x + y;
            1:       return x - y;
            2:       return (x > y) ? x : y;
            default: return (x < y) ? x : y;
        endcase
    endfunction

    function automatic logic [7:0] size8(input int m, input int r);
`ifdef MATRIX_EW_SAT_EN
        if (m == 1) begin
            if (r > 127)  return 8'h7f;
            if (r < -128) return 8'h80;
        end else if (r > 255) begin
            return 8'hff;
        end
`endif
        return 8'(r);
    endfunction

    function automatic mat16_t build16(input int m, input mat_in_t aa, input mat_in_t bb);
        mat16_t e;
        for (int r = 0; r < ROWS; r++)
            for (int k = 0; k < COLS; k++)
                e[r][k] = 16'(raw_op(m, int'(aa[r][k]), int'(bb[r][k])));
        return e;
    endfunction

    function automatic mat8_t build8(input int m, input mat_in_t aa, input mat_in_t bb);
        mat8_t e;
        for (int r = 0; r < ROWS; r++)
            for (int k = 0; k < COLS; k++)
                e[r][k] = size8(m, raw_op(m, int'(aa[r][k]), int'(bb[r][k])));
        return e;
    endfunction

    function automatic mat_in_t rnd_mat();
        mat_in_t m;
        for (int r = 0; r < ROWS; r++)
            for (int k = 0; k < COLS; k++)
                m[r][k] = 8'($urandom_range(0, 255));
        return m;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_mat16(input mat16_t e);
        int bad = -1;
        for (int r = 0; r < ROWS; r++)
            for (int k = 0; k < COLS; k++)
                if (c[r][k] !== e[r][k] && bad < 0) bad = r * COLS + k;
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("FAIL c16[%0d][%0d] actual=%h required=%h", bad / COLS, bad % COLS,
                     c[bad / COLS][bad % COLS], e[bad / COLS][bad % COLS]);
        end
    endtask

    task automatic check_mat8(input mat8_t e);
        int bad = -1;
        for (int r = 0; r < ROWS; r++)
            for (int k = 0; k < COLS; k++)
                if (c8[r][k] !== e[r][k] && bad < 0) bad = r * COLS + k;
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("FAIL c8[%0d][%0d] actual=%h required=%h", bad / COLS, bad % COLS,
                     c8[bad / COLS][bad % COLS], e[bad / COLS][bad % COLS]);
        end
    endtask

    // Monitors: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (q16.size() == 0) begin
                check("unexpected_done16", 64'(done), 64'd0);
            end else begin
                e16 = q16.pop_front();
                check_mat16(e16);
            end
        end
        if (!rst && done8) begin
            if (q8.size() == 0) begin
                check("unexpected_done8", 64'(done8), 64'd0);
            end else begin
                e8 = q8.pop_front();
                check_mat8(e8);
            end
        end
    end

    task automatic issue16(input int m, input mat_in_t aa, input mat_in_t bb);
        a = aa; b = bb; mode = 2'(m); start = 1'b1;
        q16.push_back(build16(m, aa, bb));
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic issue8(input int m, input mat_in_t aa, input mat_in_t bb);
        a = aa; b = bb; mode = 2'(m); start8 = 1'b1;
        q8.push_back(build8(m, aa, bb));
        @(posedge clk); #1;
        start8 = 1'b0;
    endtask

    // Counts falling edges until done; busy must stay high meanwhile.
    task automatic wait_done(input bit sel8, input int exp_n, input string name);
        int  n    = 0;
        bit  seen = 1'b0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(negedge clk);
            if (sel8 ? done8 : done) begin
                seen = 1'b1;
                n    = i;
            end else begin
                check({name, "_busy"}, 64'(sel8 ? busy8 : busy), 64'd1);
            end
        end
        check({name, "_latency"}, 64'(n), 64'(exp_n));
    endtask

    mat_in_t aa, bb;

    initial begin
        rst = 1'b1; start = 1'b0; start8 = 1'b0; mode = 2'd0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_c_zero", 64'(c == '0), 64'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        // All-ones add
        issue16(0, '1, '1);
        wait_done(1'b0, ROWS + 1, "add_ff");
        check("add_c33", 64'(c[3][3]), 64'd510);

        // Sub with negative result and zero element
        aa = rnd_mat(); bb = rnd_mat();
        aa[1][2] = 8'd3; bb[1][2] = 8'd5; aa[0][0] = 8'd0; bb[0][0] = 8'd0;
        issue16(1, aa, bb);
        wait_done(1'b0, ROWS + 1, "sub");
        check("sub_c12", 64'(c[1][2]), 64'hfffe);
        check("sub_c00", 64'(c[0][0]), 64'd0);

        // Max / min
        aa = rnd_mat(); bb = rnd_mat();
        aa[3][3] = 8'd17; bb[3][3] = 8'd200;
        issue16(2, aa, bb);
        wait_done(1'b0, ROWS + 1, "max");
        check("max_c33", 64'(c[3][3]), 64'd200);
        issue16(3, aa, bb);
        wait_done(1'b0, ROWS + 1, "min");
        check("min_c33", 64'(c[3][3]), 64'd17);

        // Start while busy is ignored; operands changed after capture
        issue16(0, rnd_mat(), rnd_mat());
        a = rnd_mat(); b = rnd_mat();
        @(posedge clk); #1;
        start = 1'b1; mode = 2'd1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(1'b0, ROWS - 1, "busy_ign");
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("busy_single_done", 64'(done), 64'd0);
        end

        // Back-to-back via start during done
        issue16(2, rnd_mat(), rnd_mat());
        wait_done(1'b0, ROWS + 1, "b2b_first");
        issue16(3, rnd_mat(), rnd_mat());
        wait_done(1'b0, ROWS + 1, "b2b_second");

        // Reset mid-operation
        @(posedge clk); #1;
        issue16(0, rnd_mat(), rnd_mat());
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        void'(q16.pop_back());
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_c_zero", 64'(c == '0), 64'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("midrst_no_done", 64'(done), 64'd0);
        end
        @(posedge clk); #1;
        issue16(1, rnd_mat(), rnd_mat());
        wait_done(1'b0, ROWS + 1, "after_rst");

        // Random operations
        for (int t = 0; t < 6; t++) begin
            issue16(int'($urandom_range(0, 3)), rnd_mat(), rnd_mat());
            wait_done(1'b0, ROWS + 1, "rand16");
        end

        // Narrow output instance
        aa = '0; bb = '0;
        for (int r = 0; r < ROWS; r++)
            for (int k = 0; k < COLS; k++) begin
                aa[r][k] = 8'd200; bb[r][k] = 8'd100;
            end
        issue8(0, aa, bb);
        wait_done(1'b1, ROWS + 1, "add8");
`ifdef MATRIX_EW_SAT_EN
        check("add8_c00", 64'(c8[0][0]), 64'd255);
`else
        check("add8_c00", 64'(c8[0][0]), 64'd44);
`endif
        issue8(1, '0, '1);
        wait_done(1'b1, ROWS + 1, "sub8");
`ifdef MATRIX_EW_SAT_EN
        check("sub8_c21", 64'(c8[2][1]), 64'h80);
`else
        check("sub8_c21", 64'(c8[2][1]), 64'h01);
`endif
        for (int t = 0; t < 4; t++) begin
            issue8(int'($urandom_range(0, 3)), rnd_mat(), rnd_mat());
            wait_done(1'b1, ROWS + 1, "rand8");
        end

        repeat (2) @(posedge clk);
        check("q16_drained", 64'(q16.size()), 64'd0);
        check("q8_drained", 64'(q8.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
